fifo_pkt_sched: RTL

- Round-robin packet scheduler that shares the write side of one 4096x18 dual-clock packet FIFO between NUM_CH producer channels.
- Grants a channel only when that channel has a whole packet ready and the FIFO has room for a whole packet.
- Streams the packet as PKT_LEN 18-bit words tagged {eop, sop, data[15:0]}.
- Owns the FIFO's aclr for flushes; sits in the write-clock domain between channel buffers and the FIFO.

---
 rtl/fifo_pkt_sched.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/fifo_pkt_sched.sv
// rtl/fifo_pkt_sched.sv - round-robin whole-packet writer into a shared FIFO
// Optional packet/abort counters are built when FIFO_PKT_SCHED_STATS_EN is defined.
module fifo_pkt_sched #(
  parameter int NUM_CH       = 4,
  parameter int CH_BITS      = 2,
  parameter int PKT_LEN      = 256,
  parameter int DEPTH        = 4096,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_CH-1:0]    ch_pkt_rdy,
  input  logic [16*NUM_CH-1:0] ch_data,
  output logic [NUM_CH-1:0]    ch_rd,
  input  logic                 flush,
  output logic [17:0]          fifo_data,
  output logic                 fifo_wrreq,
  input  logic                 fifo_wrfull,
  input  logic [11:0]          fifo_wrusedw,
  output logic                 fifo_aclr,
  output logic                 busy,
  output logic [CH_BITS-1:0]   cur_ch
`ifdef FIFO_PKT_SCHED_STATS_EN
  ,
  output logic [15:0]          pkt_cnt,
  output logic [7:0]           abort_cnt
`endif
);

  localparam int CNT_W = $clog2(PKT_LEN);
  localparam int FL_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [12:0] SPACE_MAX = 13'(DEPTH - PKT_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PKT_LEN - 1);
  localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, FLUSH = 2'd2} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [FL_W-1:0]    fl_cnt;
  logic               space_ok;
  logic               grant_vld;
  logic               grant_go;
  logic [CH_BITS-1:0] grant_ch;
  logic               rd_en;
  logic [15:0]        sel_data;

  assign space_ok = !fifo_wrfull && ({1'b0, fifo_wrusedw} <= SPACE_MAX);
  assign grant_go = !flush && space_ok && grant_vld;

  // Scan from the farthest offset down so the nearest ready channel after cur_ch wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = cur_ch;
    for (int i = NUM_CH; i >= 1; i--) begin
      if (ch_pkt_rdy[(int'(cur_ch) + i) % NUM_CH]) begin
        grant_vld = 1'b1;
        grant_ch  = CH_BITS'((int'(cur_ch) + i) % NUM_CH);
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cur_ch == CH_BITS'(i)) sel_data = ch_data[16*i +: 16];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (flush)         state_nxt = FLUSH;
        else if (grant_go) state_nxt = XFER;
      end
      XFER: begin
        if (flush)                          state_nxt = FLUSH;
        else if (rd_en && cnt == CNT_LAST)  state_nxt = IDLE;
      end
      FLUSH: begin
        if (fl_cnt == FL_LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pop is combinational so a full flag or flush stops the channel in the same cycle.
  always_comb begin
    rd_en = (state == XFER) && !fifo_wrfull && !flush;
    busy  = (state != IDLE);
    ch_rd = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_rd[i] = rd_en && (cur_ch == CH_BITS'(i));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cur_ch     <= CH_BITS'(NUM_CH - 1);
      cnt        <= '0;
      fl_cnt     <= '0;
      fifo_wrreq <= 1'b0;
      fifo_data  <= '0;
      fifo_aclr  <= 1'b0;
    end else begin
      fifo_wrreq <= rd_en;
      // Registered so the asynchronous clear into the FIFO never glitches.
      fifo_aclr  <= (state_nxt == FLUSH);
      if (rd_en) begin
        fifo_data <= {cnt == CNT_LAST, cnt == '0, sel_data};
        cnt       <= cnt + 1'b1;
      end
      if (state == IDLE && grant_go) begin
        cur_ch <= grant_ch;
        cnt    <= '0;
      end
      if (state == FLUSH) fl_cnt <= fl_cnt + 1'b1;
      else                fl_cnt <= '0;
    end
  end

`ifdef FIFO_PKT_SCHED_STATS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pkt_cnt   <= '0;
      abort_cnt <= '0;
    end else begin
      if (fifo_wrreq && fifo_data[17]) pkt_cnt <= pkt_cnt + 1'b1;
      if (state == XFER && state_nxt == FLUSH && abort_cnt != 8'hFF)
        abort_cnt <= abort_cnt + 1'b1;
    end
  end
`endif

endmodule
